src_stream_pack: RTL
====================

SRC_STREAM_PACK -- requirements
Module: src_stream_pack

Interface
REQ-001 Parameter DEPTH, default 4: output FIFO entries (power of two, >=2).
REQ-002 Parameter PAD, default 16'h0000: fill value for unpaired lanes (fp16 +0).
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 s_valid  in  1  upstream (DMA) beat valid.
REQ-006 s_data  in  32  upstream beat: [15:0] lane even, [31:16] lane odd.
REQ-007 s_last  in  1  final beat of a transfer.
REQ-008 s_ready  out  1  beat accepted when s_valid & s_ready.
REQ-009 src_valid  out  1  packed word valid toward accelerator source port.
REQ-010 src_data0..src_data3  out  16 each  packed fp16 lanes.
REQ-011 src_last  out  1  packed word is last of transfer.
REQ-012 src_ready  in  1  word consumed when src_valid & src_ready.
REQ-013 busy  out  1  half word held or FIFO non-empty.
REQ-014 words  out  16  packed words emitted since last s_last-terminated transfer completed.

Function
REQ-015 Two-phase packer: phase A (hold empty), phase B (hold contains one beat).
REQ-016 Phase A accept, s_last=0: store beat in hold register, go to B; no FIFO write.
REQ-017 Phase A accept, s_last=1: push {PAD,PAD,s_data[31:16],s_data[15:0]} with last=1; stay in A.
REQ-018 Phase B accept: push word data0=hold[15:0], data1=hold[31:16], data2=s_data[15:0], data3=s_data[31:16], last=s_last; go to A.
REQ-019 s_ready = FIFO not full (registered occupancy) in both phases; simultaneous pop while full does not raise s_ready in that cycle.
REQ-020 FIFO push and pop in same cycle with occupancy 1..DEPTH-1: occupancy unchanged, order preserved.
REQ-021 Latency: word visible on src_valid/src_data* the cycle after its completing beat is accepted (first-word fall-through from FIFO head register).
REQ-022 src_data*/src_last hold stable while src_valid=1 and src_ready=0.
REQ-023 Empty FIFO: src_valid=0; src_data* hold last value (don't-care to consumer).
REQ-024 Sustained throughput: one word per two input beats with no stall when src_ready=1 continuously.
REQ-025 words increments on each pop; resets to 0 the cycle after a pop with src_last=1; wraps 16'hFFFF->0.
REQ-026 busy = phase B | occupancy != 0.

Reset
REQ-027 rst_n low: phase A, FIFO empty, hold cleared to 0, words=0, src_valid=0, s_ready=0, src_last=0, busy=0.
REQ-028 s_ready rises first cycle after rst_n deasserted; reset mid-transfer discards held beat and all queued words, no partial output.

Structure
REQ-029 DEPTH default and PAD default as constants in shared package tiny_dnn_pkg, with packed-word typedef {last, 4x16 lanes}.
REQ-030 One sub-module: stream_fifo (parameterised width/depth, async active-low reset, full/empty/count); packer phase logic in top.

Verification
REQ-031 Beats 32'h2222_1111, 32'h4444_3333(last), src_ready=1 -> one word data0..3 = 1111,2222,3333,4444, src_last=1, one cycle after second beat; words 1 then 0.
REQ-032 Single beat 32'hBBBB_AAAA with s_last -> data0=AAAA, data1=BBBB, data2=data3=0000, src_last=1.
REQ-033 src_ready=0, stream 10 beats, DEPTH=4 -> s_ready drops after 4 words + 0 held... exactly 8 beats accepted; release src_ready -> 4 words in order, then remaining beats accepted.
REQ-034 Continuous 64 beats, last on 64th, src_ready=1 -> 32 words, no bubble after first, only word 32 has src_last.
REQ-035 rst_n pulsed low while phase B with 2 words queued -> src_valid=0 asynchronously, busy=0, subsequent transfer packs from fresh phase A.
REQ-036 Random src_ready toggling (50%) over 1000 beats -> output matches scoreboard model, no drop/duplicate, data stable under backpressure.

Source files
------------

// File: rtl/tiny_dnn_pkg.sv
// Shared constants and types for the DMA-to-accelerator stream packer.
// A packed word carries four fp16 lanes plus an end-of-transfer flag.
package tiny_dnn_pkg;

  localparam int          DEPTH_DEF = 4;
  localparam logic [15:0] PAD_DEF   = 16'h0000;

  typedef struct packed {
    logic        last;
    logic [15:0] data3;
    logic [15:0] data2;
    logic [15:0] data1;
    logic [15:0] data0;
  } packed_word_t;

  localparam int PACK_W = $bits(packed_word_t);

  // PH_A: hold register empty; PH_B: hold register carries one beat.
  typedef enum logic {
    PH_A = 1'b0,
    PH_B = 1'b1
  } phase_t;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with first-word fall-through read and registered occupancy.
// When empty, dout keeps showing the most recently popped entry.
module stream_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] head_idx;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_idx = empty ? (rd_ptr - PTR_ONE) : rd_ptr;
  assign dout     = mem[head_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/src_stream_pack.sv
// Packs pairs of 32-bit DMA beats (two fp16 lanes each) into four-lane words
// queued toward the accelerator source port; a lone final beat is padded.
module src_stream_pack
  import tiny_dnn_pkg::*;
#(
  parameter int          DEPTH = DEPTH_DEF,
  parameter logic [15:0] PAD   = PAD_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic        src_valid,
  output logic [15:0] src_data0,
  output logic [15:0] src_data1,
  output logic [15:0] src_data2,
  output logic [15:0] src_data3,
  output logic        src_last,
  input  logic        src_ready,
  output logic        busy,
  output logic [15:0] words,
  output phase_t      phase
);

  // Handshake: a transfer happens on any rising edge where valid & ready are
  // both high; valid never waits on ready, and ready depends only on registers.

  phase_t       phase_q, phase_d;
  logic [31:0]  hold_q, hold_d;
  logic         ready_en;
  logic         accept;
  logic         push;
  logic         pop;
  packed_word_t push_word;
  packed_word_t head;
  logic         fifo_full;
  logic         fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic         clr_pending;

  assign s_ready   = ready_en & ~fifo_full;
  assign accept    = s_valid & s_ready;
  assign src_valid = ~fifo_empty;
  assign pop       = src_valid & src_ready;
  assign busy      = (phase_q == PH_B) | (fifo_count != '0);
  assign phase     = phase_q;

  assign src_data0 = head.data0;
  assign src_data1 = head.data1;
  assign src_data2 = head.data2;
  assign src_data3 = head.data3;
  assign src_last  = head.last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= PH_A;
      hold_q   <= '0;
      ready_en <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      hold_q   <= hold_d;
      ready_en <= 1'b1;
    end
  end

  always_comb begin
    phase_d   = phase_q;
    hold_d    = hold_q;
    push      = 1'b0;
    push_word = '0;
    case (phase_q)
      PH_A: begin
        if (accept) begin
          if (s_last) begin
            push            = 1'b1;
            push_word.last  = 1'b1;
            push_word.data0 = s_data[15:0];
            push_word.data1 = s_data[31:16];
            push_word.data2 = PAD;
            push_word.data3 = PAD;
          end else begin
            hold_d  = s_data;
            phase_d = PH_B;
          end
        end
      end
      PH_B: begin
        if (accept) begin
          push            = 1'b1;
          push_word.last  = s_last;
          push_word.data0 = hold_q[15:0];
          push_word.data1 = hold_q[31:16];
          push_word.data2 = s_data[15:0];
          push_word.data3 = s_data[31:16];
          phase_d         = PH_A;
        end
      end
      default: phase_d = PH_A;
    endcase
  end

  // The counter shows the final word of a transfer for one cycle before clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words       <= '0;
      clr_pending <= 1'b0;
    end else begin
      if (clr_pending) words <= pop ? 16'd1 : 16'd0;
      else if (pop)    words <= words + 16'd1;
      clr_pending <= pop & head.last;
    end
  end

  stream_fifo #(
    .W     (PACK_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_word),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
